// File: rtl/div.sv
// rtl/div.sv - 32-bit restoring divider for the HI/LO unit, one quotient bit per clock.
// Define DIV_SIGNED_EN for signed (MIPS DIV) operation; otherwise unsigned (DIVU).
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RegAOut,
  input  logic [31:0] RegBOut,
  input  logic        DivCtrl,
  output logic        DivDone,
  output logic        Div0,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_phase;
  state_t      w_next;

  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_active;
  logic        init_done;

  logic        r_ctrl_q;
  logic [4:0]  r_count;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_div0;

  logic        w_start;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_sub;
  logic        w_ge;

`ifdef DIV_SIGNED_EN
  assign w_a_neg = RegAOut[31];
  assign w_b_neg = RegBOut[31];
`else
  assign w_a_neg = 1'b0;
  assign w_b_neg = 1'b0;
`endif

  assign w_a_mag = w_a_neg ? (~RegAOut + 32'd1) : RegAOut;
  assign w_b_mag = w_b_neg ? (~RegBOut + 32'd1) : RegBOut;
  assign w_start = DivCtrl & ~r_ctrl_q;

  // 33-bit partial remainder so divisors with bit 31 set still compare correctly.
  assign w_shift = {remainder, dividend[31]};
  assign w_sub   = w_shift - {1'b0, divisor};
  assign w_ge    = (w_shift >= {1'b0, divisor});

  // INIT is never held: it is the IDLE cycle in which a start edge is seen.
  always_comb begin
    w_phase = r_state;
    w_next  = r_state;
    if (r_state == S_IDLE && w_start) begin
      w_phase = S_INIT;
    end
    case (w_phase)
      S_IDLE:  w_next = S_IDLE;
      S_INIT:  w_next = (RegBOut == 32'd0) ? S_DONE : S_RUN;
      S_RUN:   w_next = (r_count == 5'd31) ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dividend   <= 32'd0;
      divisor    <= 32'd0;
      quotient   <= 32'd0;
      remainder  <= 32'd0;
      div_active <= 1'b0;
      init_done  <= 1'b0;
      r_ctrl_q   <= 1'b0;
      r_count    <= 5'd0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_div0     <= 1'b0;
      DivDone    <= 1'b0;
      Div0       <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
    end else begin
      r_ctrl_q <= DivCtrl;
      DivDone  <= 1'b0;
      Div0     <= 1'b0;
      case (w_phase)
        S_INIT: begin
          dividend   <= w_a_mag;
          divisor    <= w_b_mag;
          quotient   <= 32'd0;
          remainder  <= 32'd0;
          div_active <= 1'b1;
          init_done  <= 1'b1;
          r_count    <= 5'd0;
          r_qneg     <= w_a_neg ^ w_b_neg;
          r_rneg     <= w_a_neg;
          r_div0     <= (RegBOut == 32'd0);
        end
        S_RUN: begin
          dividend  <= {dividend[30:0], 1'b0};
          remainder <= w_ge ? w_sub[31:0] : w_shift[31:0];
          quotient  <= {quotient[30:0], w_ge};
          r_count   <= r_count + 5'd1;
        end
        S_DONE: begin
          DivDone    <= 1'b1;
          div_active <= 1'b0;
          init_done  <= 1'b0;
          if (r_div0) begin
            Div0 <= 1'b1;
          end else begin
            LO <= r_qneg ? (~quotient + 32'd1) : quotient;
            HI <= r_rneg ? (~remainder + 32'd1) : remainder;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div against an arithmetic reference model.
// Honours DIV_SIGNED_EN the same way as the design.
module tb_div;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RegAOut;
  logic [31:0] RegBOut;
  logic        DivCtrl;
  logic        DivDone;
  logic        Div0;
  logic [31:0] HI;
  logic [31:0] LO;

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  div dut (
    .clk     (clk),
    .reset   (reset),
    .RegAOut (RegAOut),
    .RegBOut (RegBOut),
    .DivCtrl (DivCtrl),
    .DivDone (DivDone),
    .Div0    (Div0),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division; remainder follows the dividend.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
`else
    q = a / b;
    r = a % b;
`endif
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
    int          n;
    int          extra;
    logic [31:0] eq;
    logic [31:0] er;
    bit          z;
    z  = (b == 32'd0);
    eq = 32'd0;
    er = 32'd0;
    if (!z) model(a, b, eq, er);
    @(negedge clk);
    RegAOut = a;
    RegBOut = b;
    DivCtrl = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("active_after_start", {31'd0, dut.div_active}, 32'd1);
        RegAOut = $urandom;
        RegBOut = $urandom;
      end
    end while (!DivDone && n < 40);
    check("latency", n, z ? 32'd2 : 32'd34);
    check("div0_flag", {31'd0, Div0}, {31'd0, z});
    if (!z) begin
      exp_lo = eq;
      exp_hi = er;
    end
    check("LO", LO, exp_lo);
    check("HI", HI, exp_hi);
    @(negedge clk);
    check("done_one_cycle", {31'd0, DivDone}, 32'd0);
    check("div0_one_cycle", {31'd0, Div0}, 32'd0);
    if (hold) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (DivDone) extra++;
      end
      check("no_retrigger", extra, 32'd0);
    end
    DivCtrl = 1'b0;
  endtask

  initial begin
    int          seen;
    logic [31:0] ra;
    logic [31:0] rb;
    reset   = 1'b1;
    RegAOut = 32'd0;
    RegBOut = 32'd0;
    DivCtrl = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_DivDone", {31'd0, DivDone}, 32'd0);
    check("rst_Div0", {31'd0, Div0}, 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    check("rst_dividend", dut.dividend, 32'd0);
    check("rst_divisor", dut.divisor, 32'd0);
    check("rst_quotient", dut.quotient, 32'd0);
    check("rst_remainder", dut.remainder, 32'd0);
    check("rst_active", {30'd0, dut.div_active, dut.init_done}, 32'd0);
    reset = 1'b0;

    do_op(32'd23, 32'd7, 1'b1);
    check("lit_23_7_LO", LO, 32'd3);
    check("lit_23_7_HI", HI, 32'd2);
    do_op(32'hFFFF_FFE9, 32'd7, 1'b0);
    do_op(32'h1234_5678, 32'd0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

    @(negedge clk);
    RegAOut = 32'd100;
    RegBOut = 32'd9;
    DivCtrl = 1'b1;
    repeat (11) @(negedge clk);
    reset   = 1'b1;
    DivCtrl = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (DivDone) seen++;
    end
    check("abort_no_done", seen, 32'd0);
    check("abort_HI", HI, 32'd0);
    check("abort_LO", LO, 32'd0);
    check("abort_active", {31'd0, dut.div_active}, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    do_op(32'd100, 32'd9, 1'b0);
    check("lit_100_9_LO", LO, 32'd11);
    check("lit_100_9_HI", HI, 32'd1);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
